// File: rtl/riscv_pkg.sv
// Shared pipeline types: ALU opcodes, write-back selects and the EX control bundle.
package riscv_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef struct packed {
        alu_op_e alu_ctrl;
        logic    sel_a;
        logic    sel_b;
        logic    rd_wr;
        logic    mem_rd;
        logic    mem_wr;
        wb_sel_e wb_sel;
    } ex_ctrl_t;

    // All-zero control word: ADD, no register or memory side effects.
    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand bypass for one EX source register: MEM result first,
// then WB data, otherwise the value captured from the register file.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [XLEN-1:0]      rdata,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_rd_wr,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_rd_wr,
    input  logic [XLEN-1:0]      wb_wdata,
    output logic [XLEN-1:0]      fwd
);

    logic rs_nz_s;
    logic mem_hit_s;
    logic wb_hit_s;

    assign rs_nz_s   = (rs != {REG_IDX_W{1'b0}});
    assign mem_hit_s = mem_rd_wr && (mem_rd == rs) && rs_nz_s;
    assign wb_hit_s  = wb_rd_wr  && (wb_rd  == rs) && rs_nz_s;

    // Bypass select: the younger MEM result shadows an older WB write.
    always_comb begin
        fwd = rdata;
        if (mem_hit_s) begin
            fwd = mem_result;
        end else if (wb_hit_s) begin
            fwd = wb_wdata;
        end else begin
            fwd = rdata;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand
// forwarding/selection feeding the ALU.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]      id_rdata1,
    input  logic [XLEN-1:0]      id_rdata2,
    input  logic [XLEN-1:0]      id_imm,
    input  ex_ctrl_t             id_ctrl,
    input  logic                 hold,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_rd_wr,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_rd_wr,
    input  logic [XLEN-1:0]      wb_wdata,
    output logic [XLEN-1:0]      rdataA,
    output logic [XLEN-1:0]      rdataB,
    output logic [3:0]           ALU_control,
    output logic [XLEN-1:0]      ex_store_data,
    output logic [XLEN-1:0]      ex_pc,
    output logic [REG_IDX_W-1:0] ex_rd,
    output ex_ctrl_t             ex_ctrl,
    output logic                 ex_valid,
    output logic                 stall_id
);

    logic                 ex_valid_q,  ex_valid_d;
    ex_ctrl_t             ex_ctrl_q,   ex_ctrl_d;
    logic [XLEN-1:0]      ex_pc_q,     ex_pc_d;
    logic [REG_IDX_W-1:0] ex_rd_q,     ex_rd_d;
    logic [REG_IDX_W-1:0] ex_rs1_q,    ex_rs1_d;
    logic [REG_IDX_W-1:0] ex_rs2_q,    ex_rs2_d;
    logic [XLEN-1:0]      ex_rdata1_q, ex_rdata1_d;
    logic [XLEN-1:0]      ex_rdata2_q, ex_rdata2_d;
    logic [XLEN-1:0]      ex_imm_q,    ex_imm_d;

    logic                 hazard_s;
    logic [XLEN-1:0]      fwd_rs1_s;
    logic [XLEN-1:0]      fwd_rs2_s;

    // A load in EX whose destination feeds the decode instruction cannot be bypassed yet.
    assign hazard_s = ex_valid_q && ex_ctrl_q.mem_rd
                   && (ex_rd_q != {REG_IDX_W{1'b0}})
                   && ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2))
                   && id_valid;

    assign stall_id = hazard_s && !flush && !hold;

    // Next-state selection: hold > flush > hazard bubble > load from decode.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_pc_d     = ex_pc_q;
        ex_rd_d     = ex_rd_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_rdata1_d = ex_rdata1_q;
        ex_rdata2_d = ex_rdata2_q;
        ex_imm_d    = ex_imm_q;
        if (hold) begin
            ex_valid_d = ex_valid_q;
        end else if (flush || hazard_s) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_BUBBLE;
        end else begin
            ex_valid_d  = id_valid;
            ex_ctrl_d   = id_valid ? id_ctrl : CTRL_BUBBLE;
            ex_pc_d     = id_pc;
            ex_rd_d     = id_rd;
            ex_rs1_d    = id_rs1;
            ex_rs2_d    = id_rs2;
            ex_rdata1_d = id_rdata1;
            ex_rdata2_d = id_rdata2;
            ex_imm_d    = id_imm;
        end
    end

    // EX-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_BUBBLE;
            ex_pc_q     <= {XLEN{1'b0}};
            ex_rd_q     <= {REG_IDX_W{1'b0}};
            ex_rs1_q    <= {REG_IDX_W{1'b0}};
            ex_rs2_q    <= {REG_IDX_W{1'b0}};
            ex_rdata1_q <= {XLEN{1'b0}};
            ex_rdata2_q <= {XLEN{1'b0}};
            ex_imm_q    <= {XLEN{1'b0}};
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_pc_q     <= ex_pc_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rdata1_q <= ex_rdata1_d;
            ex_rdata2_q <= ex_rdata2_d;
            ex_imm_q    <= ex_imm_d;
        end
    end

    forward_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs         (ex_rs1_q),
        .rdata      (ex_rdata1_q),
        .mem_rd     (mem_rd),
        .mem_rd_wr  (mem_rd_wr),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_rd_wr   (wb_rd_wr),
        .wb_wdata   (wb_wdata),
        .fwd        (fwd_rs1_s)
    );

    forward_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs         (ex_rs2_q),
        .rdata      (ex_rdata2_q),
        .mem_rd     (mem_rd),
        .mem_rd_wr  (mem_rd_wr),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_rd_wr   (wb_rd_wr),
        .wb_wdata   (wb_wdata),
        .fwd        (fwd_rs2_s)
    );

    // Store data always takes the bypassed rs2, even when operand B is the immediate.
    assign rdataA        = ex_ctrl_q.sel_a ? ex_pc_q  : fwd_rs1_s;
    assign rdataB        = ex_ctrl_q.sel_b ? ex_imm_q : fwd_rs2_s;
    assign ex_store_data = fwd_rs2_s;
    assign ALU_control   = ex_ctrl_q.alu_ctrl;

    assign ex_pc    = ex_pc_q;
    assign ex_rd    = ex_rd_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector table plus hand-written flush/hold/reset sequences for id_ex_stage.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    ex_ctrl_t    id_ctrl;
    logic        hold, flush;
    logic [4:0]  mem_rd;
    logic        mem_rd_wr;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_rd_wr;
    logic [31:0] wb_wdata;
    logic [31:0] rdataA, rdataB, ex_store_data, ex_pc;
    logic [3:0]  ALU_control;
    logic [4:0]  ex_rd;
    ex_ctrl_t    ex_ctrl;
    logic        ex_valid, stall_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
        .mem_rd(mem_rd), .mem_rd_wr(mem_rd_wr), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_rd_wr(wb_rd_wr), .wb_wdata(wb_wdata),
        .rdataA(rdataA), .rdataB(rdataB), .ALU_control(ALU_control),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .stall_id(stall_id)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        ex_ctrl_t    ctrl;
        logic [4:0]  mrd;
        logic        mwr;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wwr;
        logic [31:0] wdat;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [3:0]  e_alu;
        logic        chk_ops;
        logic [31:0] e_a, e_b, e_st;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ex_ctrl_t mkc(alu_op_e op, logic sa, logic sb, logic rw,
                                     logic mr, logic mw, wb_sel_e wb);
        ex_ctrl_t c;
        c.alu_ctrl = op;
        c.sel_a    = sa;
        c.sel_b    = sb;
        c.rd_wr    = rw;
        c.mem_rd   = mr;
        c.mem_wr   = mw;
        c.wb_sel   = wb;
        return c;
    endfunction

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input ex_ctrl_t c);
        id_valid  = v;
        id_pc     = pc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_rdata1 = d1;
        id_rdata2 = d2;
        id_imm    = imm;
        id_ctrl   = c;
    endtask

    task automatic no_fwd();
        mem_rd = 5'd0; mem_rd_wr = 1'b0; mem_result = 32'd0;
        wb_rd  = 5'd0; wb_rd_wr  = 1'b0; wb_wdata   = 32'd0;
    endtask

    ex_ctrl_t c_add, c_addi, c_auipc, c_sub, c_or, c_xor, c_and, c_lw, c_passb;

    initial begin
        c_add   = mkc(ALU_ADD,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_addi  = mkc(ALU_ADD,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_auipc = mkc(ALU_ADD,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_sub   = mkc(ALU_SUB,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_or    = mkc(ALU_OR,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_xor   = mkc(ALU_XOR,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_and   = mkc(ALU_AND,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WB_ALU);
        c_lw    = mkc(ALU_ADD,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, WB_MEM);
        c_passb = mkc(ALU_PASSB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, WB_IMM);

        //            v     pc            rs1   rs2   rd    d1          d2          imm         ctrl     mrd  mwr   mres         wrd  wwr   wdat         stall valid e_rd  alu    ops   A            B            store
        tbl[0]  = '{1'b1, 32'h0000_0010, 5'd1, 5'd2, 5'd3, 32'd5,      32'd7,      32'd0,      c_add,   5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd3, 4'h0, 1'b1, 32'd5,       32'd7,       32'd7};
        tbl[1]  = '{1'b1, 32'h0000_0014, 5'd1, 5'd2, 5'd4, 32'd10,     32'd3,      32'h20,     c_addi,  5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd4, 4'h0, 1'b1, 32'd10,      32'h20,      32'd3};
        tbl[2]  = '{1'b1, 32'h0000_0100, 5'd0, 5'd0, 5'd8, 32'd0,      32'd0,      32'h1000,   c_auipc, 5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd8, 4'h0, 1'b1, 32'h100,     32'h1000,    32'd0};
        tbl[3]  = '{1'b1, 32'h0000_0104, 5'd4, 5'd0, 5'd7, 32'h99,     32'h55,     32'd0,      c_sub,   5'd4, 1'b1, 32'hA,       5'd4, 1'b1, 32'hB,       1'b0, 1'b1, 5'd7, 4'h1, 1'b1, 32'hA,       32'h55,      32'h55};
        tbl[4]  = '{1'b1, 32'h0000_0108, 5'd0, 5'd0, 5'd9, 32'd0,      32'd0,      32'd0,      c_or,    5'd0, 1'b1, 32'hA,       5'd0, 1'b1, 32'hB,       1'b0, 1'b1, 5'd9, 4'h8, 1'b1, 32'd0,       32'd0,       32'd0};
        tbl[5]  = '{1'b1, 32'h0000_010C, 5'd1, 5'd7, 5'd10, 32'h0F,    32'h33,     32'd0,      c_xor,   5'd7, 1'b0, 32'hDEAD,    5'd7, 1'b1, 32'hB,       1'b0, 1'b1, 5'd10, 4'h5, 1'b1, 32'h0F,     32'hB,       32'hB};
        tbl[6]  = '{1'b0, 32'h0000_0110, 5'd1, 5'd2, 5'd11, 32'd1,     32'd2,      32'd0,      c_and,   5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 32'd0,       32'd0,       32'd0};
        tbl[7]  = '{1'b1, 32'h0000_0114, 5'd1, 5'd0, 5'd5, 32'h400,    32'd0,      32'd8,      c_lw,    5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd5, 4'h0, 1'b1, 32'h400,     32'd8,       32'd0};
        tbl[8]  = '{1'b1, 32'h0000_0118, 5'd5, 5'd1, 5'd6, 32'd0,      32'd3,      32'd0,      c_add,   5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b1, 1'b0, 5'd0, 4'h0, 1'b0, 32'd0,       32'd0,       32'd0};
        tbl[9]  = '{1'b1, 32'h0000_0118, 5'd5, 5'd1, 5'd6, 32'd0,      32'd3,      32'd0,      c_add,   5'd0, 1'b0, 32'd0,       5'd5, 1'b1, 32'h1234,    1'b0, 1'b1, 5'd6, 4'h0, 1'b1, 32'h1234,    32'd3,       32'd3};
        tbl[10] = '{1'b1, 32'h0000_011C, 5'd2, 5'd0, 5'd0, 32'h500,    32'd0,      32'd0,      c_lw,    5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd0, 4'h0, 1'b1, 32'h500,     32'd0,       32'd0};
        tbl[11] = '{1'b1, 32'h0000_0120, 5'd0, 5'd0, 5'd1, 32'd0,      32'd0,      32'h77,     c_passb, 5'd0, 1'b0, 32'd0,       5'd0, 1'b0, 32'd0,       1'b0, 1'b1, 5'd1, 4'hA, 1'b1, 32'd0,       32'h77,      32'd0};

        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, '0);
        no_fwd();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ex_ctrl",  {21'd0, ex_ctrl},  32'd0);
        chk("reset ex_pc",    ex_pc,             32'd0);
        chk("reset ex_rd",    {27'd0, ex_rd},    32'd0);
        chk("reset stall_id", {31'd0, stall_id}, 32'd0);
        chk("reset rdataA",   rdataA,            32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_id(tbl[i].v, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                     tbl[i].d1, tbl[i].d2, tbl[i].imm, tbl[i].ctrl);
            mem_rd = tbl[i].mrd; mem_rd_wr = tbl[i].mwr; mem_result = tbl[i].mres;
            wb_rd  = tbl[i].wrd; wb_rd_wr  = tbl[i].wwr; wb_wdata   = tbl[i].wdat;
            #1;
            chk($sformatf("v%0d stall_id", i), {31'd0, stall_id}, {31'd0, tbl[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d ALU_control", i), {28'd0, ALU_control}, {28'd0, tbl[i].e_alu});
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].e_rd});
                chk($sformatf("v%0d ex_pc", i), ex_pc, tbl[i].pc);
            end else begin
                chk($sformatf("v%0d bubble ex_ctrl", i), {21'd0, ex_ctrl}, 32'd0);
            end
            if (tbl[i].chk_ops) begin
                chk($sformatf("v%0d rdataA", i), rdataA, tbl[i].e_a);
                chk($sformatf("v%0d rdataB", i), rdataB, tbl[i].e_b);
                chk($sformatf("v%0d store_data", i), ex_store_data, tbl[i].e_st);
            end
        end

        // Flush in the same cycle as a load-use hazard.
        @(negedge clk);
        no_fwd();
        drive_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 32'h40, 32'd0, 32'd4, c_lw);
        @(posedge clk);
        @(negedge clk);
        drive_id(1'b1, 32'h204, 5'd5, 5'd1, 5'd6, 32'd0, 32'd1, 32'd0, c_add);
        #1;
        chk("flush pre hazard stall", {31'd0, stall_id}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush stall_id", {31'd0, stall_id}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush ex_ctrl",  {21'd0, ex_ctrl},  32'd0);

        // Hold for three cycles while decode inputs keep changing.
        @(negedge clk);
        flush = 1'b0;
        drive_id(1'b1, 32'h300, 5'd2, 5'd3, 5'd9, 32'h11, 32'h22, 32'd0, c_sub);
        @(posedge clk);
        #1;
        chk("hold load ex_rd", {27'd0, ex_rd}, 32'd9);
        chk("hold load rdataA", rdataA, 32'h11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hold  = 1'b1;
            flush = (k == 1);
            drive_id(1'b1, 32'h400 + k, 5'd7, 5'd8, 5'd12 + k[4:0], 32'h90 + k, 32'h80, 32'h5, c_and);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d ex_pc", k), ex_pc, 32'h300);
            chk($sformatf("hold%0d ex_rd", k), {27'd0, ex_rd}, 32'd9);
            chk($sformatf("hold%0d ex_valid", k), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("hold%0d ALU_control", k), {28'd0, ALU_control}, 32'd1);
            chk($sformatf("hold%0d rdataB", k), rdataB, 32'h22);
        end

        // Reset arriving mid-hold clears state without waiting for a clock edge.
        @(negedge clk);
        flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midhold rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midhold rst ex_pc",    ex_pc,             32'd0);
        chk("midhold rst ex_rd",    {27'd0, ex_rd},    32'd0);
        chk("midhold rst stall_id", {31'd0, stall_id}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        drive_id(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, c_add);
        @(posedge clk);
        #1;
        chk("post rst ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("post rst rdataA",   rdataA,            32'd5);
        chk("post rst rdataB",   rdataB,            32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-005 SHALL have port id_pc  input  XLEN  PC of the decode instruction.
REQ-006 SHALL have port id_rs1 / id_rs2 / id_rd  input  5 each  register indices.
REQ-007 SHALL have port id_rdata1 / id_rdata2  input  XLEN each  register-file read data.
REQ-008 SHALL have port id_imm  input  XLEN  sign-extended immediate.
REQ-009 SHALL have port id_ctrl  input  ex_ctrl_t (11)  {alu_ctrl[3:0], sel_a, sel_b, rd_wr, mem_rd, mem_wr, wb_sel[1:0]}.
REQ-010 SHALL have port hold  input  1  downstream freeze.
REQ-011 SHALL have port flush  input  1  taken branch/trap; kill the decode instruction.
REQ-012 SHALL have port mem_rd / mem_rd_wr / mem_result  input  5/1/XLEN  MEM-stage destination, qualified write-enable, ALU result.
REQ-013 SHALL have port wb_rd / wb_rd_wr / wb_wdata  input  5/1/XLEN  WB-stage destination, qualified write-enable, write data.
REQ-014 SHALL have port rdataA / rdataB  output  XLEN each  ALU operands.
REQ-015 SHALL have port ALU_control  output  4  ALU opcode, equal to ex_ctrl.alu_ctrl.
REQ-016 SHALL have port ex_store_data  output  XLEN  forwarded rs2 value for stores.
REQ-017 SHALL have port ex_pc / ex_rd / ex_ctrl / ex_valid  output  XLEN/5/11/1  registered EX-stage state.
REQ-018 SHALL have port stall_id  output  1  freeze PC and IF/ID (load-use hazard).

Function
REQ-019 SHALL update the register set per clock with priority: hold (keep all) > flush (bubble) > hazard (bubble) > load from id_*.
REQ-020 SHALL define a bubble as ex_valid=0 and ex_ctrl all-zero (alu_ctrl=ADD, no writes); ex_pc/ex_rd/ex_rs* are don't-care.
REQ-021 SHALL load id_* when id_valid=0 with ex_valid=0 and ex_ctrl forced to zero.
REQ-022 SHALL assert hazard combinationally when ex_valid & ex_ctrl.mem_rd & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
REQ-023 SHALL drive stall_id = hazard & ~flush & ~hold.
REQ-024 SHALL forward each EX source (registered rs1/rs2) combinationally: MEM match (mem_rd_wr, mem_rd==rs, rs!=0) -> mem_result; else WB match -> wb_wdata; else registered rdata; x0 never forwarded.
REQ-025 SHALL drive rdataA = sel_a ? ex_pc : fwd_rs1 and rdataB = sel_b ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2 regardless of sel_b.
REQ-026 SHALL add zero latency from EX registers to rdataA/rdataB/ALU_control; one cycle from id_* to EX registers.
REQ-027 SHALL give MEM forwarding priority over WB when both match the same register.

Reset
REQ-028 SHALL on rst clear all registers immediately: ex_valid=0, ex_ctrl=0, ex_pc=0, ex_rd=0, operands/immediate=0; stall_id=0 while in reset.
REQ-029 SHALL load the first instruction on the first rising edge after rst deasserts; a rst mid-hold discards held state.

Structure
REQ-030 SHALL take ex_ctrl_t, alu_op_e (ADD=0000 ... AND=1001, PASSB=1010) and wb_sel_e from shared package riscv_pkg.
REQ-031 SHALL instantiate combinational sub-module forward_unit twice (rs1, rs2); hazard logic lives in id_ex_stage.

Verification
REQ-032 SHALL test: id ADD x3,x1,x2 (rdata 5,7) -> next cycle rdataA=5, rdataB=7, ALU_control=0000, ex_valid=1.
REQ-033 SHALL test: EX=LW x5; ID=ADD x6,x5,x1 -> stall_id=1 one cycle, bubble in EX, then rdataA=wb_wdata (0x1234).
REQ-034 SHALL test: mem_rd=wb_rd=4, mem_result=0xA, wb_wdata=0xB, rs1=4 -> rdataA=0xA; rs1=0 with mem_rd=0 -> rdataA=0.
REQ-035 SHALL test: flush with hazard in same cycle -> ex_valid=0 next cycle, stall_id=0.
REQ-036 SHALL test: hold=1 for 3 cycles with changing id_* -> EX registers unchanged; rst asserted mid-hold -> ex_valid=0 immediately.
